cpu_hazard_ctrl: RTL and testbench

Register-scoreboard interlock controller that sequences the instruction decode stage. It tracks destination registers with writes in flight between decode and writeback, and drives the decode stage's stall input whenever a new instruction would read or overwrite a pending register. It also holds issue during multi-cycle divide/modulo execution and caps the number of outstanding writes.

---
 rtl/cpu_hazard_ctrl_if.sv | 32 +++
 rtl/cpu_hazard_ctrl.sv | 73 +++++++
 tb/tb_cpu_hazard_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_hazard_ctrl_if.sv
// Decode-stage hazard bus between the decode/writeback side (master) and the
// scoreboard interlock controller (slave).
interface cpu_hazard_ctrl_if;
  logic        valid_i;
  logic        rd_a_en_i;
  logic [3:0]  rd_a_idx_i;
  logic        rd_b_en_i;
  logic [3:0]  rd_b_idx_i;
  logic        wr_en_i;
  logic [3:0]  wr_idx_i;
  logic        multi_i;
  logic        wb_en_i;
  logic [3:0]  wb_idx_i;
  logic        stall_o;
  logic        issue_o;
  logic [15:0] pending_o;
  logic [3:0]  inflight_o;
  logic        mc_busy_o;
  logic        err_o;

  modport master (
    output valid_i, rd_a_en_i, rd_a_idx_i, rd_b_en_i, rd_b_idx_i,
           wr_en_i, wr_idx_i, multi_i, wb_en_i, wb_idx_i,
    input  stall_o, issue_o, pending_o, inflight_o, mc_busy_o, err_o
  );

  modport slave (
    input  valid_i, rd_a_en_i, rd_a_idx_i, rd_b_en_i, rd_b_idx_i,
           wr_en_i, wr_idx_i, multi_i, wb_en_i, wb_idx_i,
    output stall_o, issue_o, pending_o, inflight_o, mc_busy_o, err_o
  );
endinterface

// File: rtl/cpu_hazard_ctrl.sv
// Register-scoreboard interlock: stalls decode on RAW/WAW hazards, a full
// write window, or while a multi-cycle op counts down in execute.
module cpu_hazard_ctrl #(
  parameter int unsigned MC_CYCLES    = 8,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cpu_hazard_ctrl_if.slave  hz
);

  localparam logic [7:0] MC_LOAD = 8'(MC_CYCLES - 1);
  localparam logic [3:0] MAX_INF = 4'(MAX_INFLIGHT);

  logic [15:0] pending_q, pending_d;
  logic [3:0]  inflight_q, inflight_d;
  logic [7:0]  mc_cnt_q, mc_cnt_d;
  logic        err_q, err_d;

  logic raw_a, raw_b, waw, full, mc_busy;
  logic stall, issue;
  logic set_wr, clr_hit, same_idx, inc, dec;

  // Hazards look only at registered state; a same-cycle writeback is not bypassed.
  assign raw_a   = hz.rd_a_en_i & pending_q[hz.rd_a_idx_i];
  assign raw_b   = hz.rd_b_en_i & pending_q[hz.rd_b_idx_i];
  assign waw     = hz.wr_en_i & pending_q[hz.wr_idx_i];
  assign full    = hz.wr_en_i & (inflight_q == MAX_INF);
  assign mc_busy = (mc_cnt_q != 8'd0);

  assign stall = hz.valid_i & (raw_a | raw_b | waw | full | mc_busy);
  assign issue = hz.valid_i & ~stall;

  assign set_wr   = issue & hz.wr_en_i;
  assign clr_hit  = hz.wb_en_i & pending_q[hz.wb_idx_i];
  // Set and clear on one index: the set wins and the count is left alone.
  assign same_idx = set_wr & hz.wb_en_i & (hz.wb_idx_i == hz.wr_idx_i);
  assign inc      = set_wr & ~same_idx;
  assign dec      = clr_hit & (inflight_q != 4'd0);

  always_comb begin
    pending_d = pending_q;
    if (clr_hit) pending_d[hz.wb_idx_i] = 1'b0;
    if (set_wr)  pending_d[hz.wr_idx_i] = 1'b1;
    inflight_d = inflight_q + {3'b000, inc} - {3'b000, dec};
    err_d      = err_q | (hz.wb_en_i & ~pending_q[hz.wb_idx_i]);
    if (issue & hz.multi_i) mc_cnt_d = MC_LOAD;
    else if (mc_busy)       mc_cnt_d = mc_cnt_q - 8'd1;
    else                    mc_cnt_d = mc_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_q  <= 16'h0000;
      inflight_q <= 4'd0;
      mc_cnt_q   <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      mc_cnt_q   <= mc_cnt_d;
      err_q      <= err_d;
    end
  end

  assign hz.stall_o    = stall;
  assign hz.issue_o    = issue;
  assign hz.pending_o  = pending_q;
  assign hz.inflight_o = inflight_q;
  assign hz.mc_busy_o  = mc_busy;
  assign hz.err_o      = err_q;

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Bench for cpu_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a scoreboard model of the interlock rules.
module tb_cpu_hazard_ctrl;
  localparam int MC   = 8;
  localparam int MAXI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_hazard_ctrl_if hz_if ();

  cpu_hazard_ctrl #(.MC_CYCLES(MC), .MAX_INFLIGHT(MAXI)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (hz_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit m_pend[16];
  int m_cnt;
  bit m_err;
  int cyc;
  int mc_free;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] m_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    m_cnt   = 0;
    m_err   = 1'b0;
    mc_free = 0;
  endtask

  task automatic drive(input bit v, input bit ae, input int a, input bit be, input int b,
                       input bit we, input int w, input bit mu, input bit wbe, input int wb);
    hz_if.valid_i    = v;
    hz_if.rd_a_en_i  = ae;
    hz_if.rd_a_idx_i = 4'(a);
    hz_if.rd_b_en_i  = be;
    hz_if.rd_b_idx_i = 4'(b);
    hz_if.wr_en_i    = we;
    hz_if.wr_idx_i   = 4'(w);
    hz_if.multi_i    = mu;
    hz_if.wb_en_i    = wbe;
    hz_if.wb_idx_i   = 4'(wb);
  endtask

  function automatic bit exp_stall();
    bit busy = (cyc < mc_free);
    bit hz   = (hz_if.rd_a_en_i && m_pend[hz_if.rd_a_idx_i]) ||
               (hz_if.rd_b_en_i && m_pend[hz_if.rd_b_idx_i]) ||
               (hz_if.wr_en_i && m_pend[hz_if.wr_idx_i]) ||
               (hz_if.wr_en_i && m_cnt == MAXI) || busy;
    return hz_if.valid_i && hz;
  endfunction

  // Called at a falling edge with inputs already driven; ends at the next falling edge.
  task automatic step();
    bit st, iss, s_wr, s_mu, s_wb;
    int s_wri, s_wbi;
    #1;
    st  = exp_stall();
    iss = hz_if.valid_i && !st;
    chk("stall", hz_if.stall_o, st);
    chk("issue", hz_if.issue_o, iss);
    s_wr = hz_if.wr_en_i; s_wri = hz_if.wr_idx_i;
    s_mu = hz_if.multi_i;
    s_wb = hz_if.wb_en_i; s_wbi = hz_if.wb_idx_i;
    @(posedge clk);
    if (s_wb) begin
      if (m_pend[s_wbi]) begin
        m_pend[s_wbi] = 1'b0;
        if (m_cnt > 0) m_cnt--;
      end else m_err = 1'b1;
    end
    if (iss && s_wr) begin
      if (!(s_wb && s_wbi == s_wri)) m_cnt++;
      m_pend[s_wri] = 1'b1;
    end
    if (iss && s_mu) mc_free = cyc + MC;
    cyc++;
    @(negedge clk);
    chk("pending", hz_if.pending_o, m_vec());
    chk("inflight", hz_if.inflight_o, m_cnt);
    chk("mc_busy", hz_if.mc_busy_o, (cyc < mc_free) ? 1 : 0);
    chk("err", hz_if.err_o, m_err);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pending", hz_if.pending_o, 0);
    chk("rst_inflight", hz_if.inflight_o, 0);
    chk("rst_err", hz_if.err_o, 0);
    chk("rst_busy", hz_if.mc_busy_o, 0);
    chk("rst_stall", hz_if.stall_o, 0);
    chk("rst_issue", hz_if.issue_o, hz_if.valid_i);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int q[$];
    model_reset();
    cyc = 0;
    drive(1, 1, 3, 0, 0, 1, 3, 0, 0, 0);
    #2;
    chk("rst_pending", hz_if.pending_o, 0);
    chk("rst_inflight", hz_if.inflight_o, 0);
    chk("rst_stall", hz_if.stall_o, 0);
    chk("rst_issue", hz_if.issue_o, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Read/write R3 out of reset
    step();
    chk("r3_pending", hz_if.pending_o, 16'h0008);
    chk("r3_inflight", hz_if.inflight_o, 1);

    // RAW on R3 through port B until retired
    drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    repeat (3) step();
    drive(1, 0, 0, 1, 3, 0, 0, 0, 1, 3);
    step();
    chk("r3_cleared", hz_if.pending_o[3], 0);
    drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    #1 chk("raw_release", hz_if.stall_o, 0);
    step();

    // Fill the write window, fourth write waits for a retire
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    #1 chk("full_stall", hz_if.stall_o, 1);
    step(); step();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 1, 1); step();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    #1 chk("full_release", hz_if.issue_o, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5); step();

    // Simultaneous issue to R2 and retire of R1
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 2, 0, 1, 1); step();
    chk("swap_pending", hz_if.pending_o, 16'h0004);
    chk("swap_inflight", hz_if.inflight_o, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2); step();

    // Multi-cycle op holds issue for MC_CYCLES-1 cycles
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (k = 1; k < 20; k++) begin
      #1;
      if (hz_if.issue_o) break;
      step();
    end
    chk("mc_gap", k, MC);
    step();

    // Stray writeback raises sticky err, pending untouched
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7); step();
    chk("err_set", hz_if.err_o, 1);
    chk("err_pending", hz_if.pending_o, 0);
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 10, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9); step();
    chk("post_rst_err", hz_if.err_o, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int wbi;
      bit wbe;
      q.delete();
      for (int i = 0; i < 16; i++) if (m_pend[i]) q.push_back(i);
      wbe = 1'b0; wbi = $urandom_range(15);
      if (q.size() > 0 && $urandom_range(9) < 4) begin
        wbe = 1'b1; wbi = q[$urandom_range(q.size() - 1)];
      end else if ($urandom_range(19) == 0) wbe = 1'b1;
      drive($urandom_range(3) != 0, $urandom_range(1), $urandom_range(15),
            $urandom_range(1), $urandom_range(15), $urandom_range(2) != 0,
            $urandom_range(15), $urandom_range(19) == 0, wbe, wbi);
      if ($urandom_range(499) == 0) mid_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
